dsm_ctrl: RTL and testbench
===========================

Name: dsm_ctrl

Overview:
Sequencer and supervisor for the delta-sigma modulator top (DSM_top).
- Accepts input samples over a valid/ready handshake and holds each sample on the modulator vin for OSR clocks.
- Generates the LFSR dither word and drives the modulator reset through start-up, shutdown and overload recovery.
- Monitors the 2-bit pwm code for overload: a run of identical saturated codes triggers a reset-and-resume.

Parameters:
T_BITS, 15, sample/vin width (two's complement)
OSR, 64, clocks per input sample (>=2)
RST_CYCLES, 4, clocks dsm_reset is held in FLUSH/RECOVER (>=1)
OVL_LIMIT, 32, consecutive identical nonzero pwm codes that declare overload (>=2)
DITH_SHIFT, 2, arithmetic right shift applied to the dither word (0..9)
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; level sensitive
dith_en  in  1  dither enable; 0 forces dsm_dith=0
s_valid  in  1  input sample valid
s_data  in  T_BITS  input sample
s_ready  out  1  controller accepts s_data this cycle
dsm_reset  out  1  to modulator reset
dsm_vin  out  T_BITS  to modulator vin
dsm_dith  out  T_BITS-5  to modulator dith_i[T_BITS-1:5]
pwm  in  2  modulator output (00=0, 01=+, 11=-)
underrun  out  1  one-cycle pulse: sample slot missed
ovl_flag  out  1  sticky overload indicator
ovl_clr  in  1  clears ovl_flag
ovl_count  out  8  overload events, saturates at 255
state  out  2  00 IDLE, 01 FLUSH, 10 RUN, 11 RECOVER

Behaviour:
Outputs and reset
- All outputs are registered.
- Reset values: state=IDLE, dsm_reset=1, dsm_vin=0, dsm_dith=0, s_ready=0, underrun=0, ovl_flag=0, ovl_count=0, lfsr=LFSR_SEED, phase=0, run counter=0.
- Reset mid-operation returns to these values on the next edge; any sample in flight is dropped.

State machine
- IDLE: dsm_reset=1, dsm_vin=0. Goes to FLUSH when enable=1.
- FLUSH: dsm_reset=1, dsm_vin=0. Counter runs 0..RST_CYCLES-1. After RST_CYCLES clocks, goes to RUN with phase=0.
- RUN: dsm_reset=0. Phase counter counts 0..OSR-1 and wraps.
  - If enable=0 in any RUN cycle, goes to IDLE next edge: dsm_reset=1, dsm_vin=0. No partial-frame completion.
- RECOVER: entered from RUN on overload. Behaves like FLUSH (dsm_reset=1, dsm_vin=0, RST_CYCLES clocks), then returns to RUN with phase=0.
  - If enable=0 during FLUSH or RECOVER, goes to IDLE.

Sample handshake
- s_ready=1 only in RUN with phase==0.
- Transfer occurs when s_ready && s_valid; dsm_vin takes s_data on the next edge and is held for OSR clocks.
- If phase==0 in RUN and s_valid=0: dsm_vin holds its previous value and underrun pulses high for exactly one cycle (the following cycle). Phase still advances.
- Latency: s_data to dsm_vin is 1 clock. s_ready is combinationally derived from registered state/phase only; there is no path from s_valid to s_ready.

Dither
- 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
- Advances once per clock in RUN only; holds in other states.
- dsm_dith = dith_en ? (signed lfsr[9:0]) >>> DITH_SHIFT : 0.
- dsm_dith is registered and forced to 0 outside RUN.

Overload detection (RUN only)
- Run counter: increments when pwm!=00 and pwm equals the previous cycle's pwm. Otherwise resets to 1 if pwm!=00, or 0 if pwm==00.
- When the run counter reaches OVL_LIMIT:
  - go to RECOVER next edge;
  - set ovl_flag;
  - increment ovl_count (saturating at 255);
  - clear the run counter.
- The run counter is cleared on every entry to RUN.
- ovl_clr and an overload in the same cycle: set wins, so ovl_flag stays 1.
- pwm is ignored outside RUN.

Test Plan:
1. Reset then enable=1 → dsm_reset high for exactly 4 clocks (FLUSH), then state=10, s_ready=1 on the first RUN cycle; all reset values checked before enable.
2. RUN, OSR=64, s_valid held high with s_data=0x1234, then 0x7000 → dsm_vin=0x1234 one clock after the handshake, held 64 clocks, then 0x7000; s_ready high exactly 1 of every 64 clocks.
3. s_valid=0 at a phase-0 slot → underrun single-cycle pulse, dsm_vin unchanged, next handshake 64 clocks later succeeds.
4. Force pwm=01 for 32 consecutive RUN cycles → state RECOVER, dsm_reset high 4 clocks, dsm_vin=0, ovl_flag=1, ovl_count=1. pwm alternating 01/11 for 1000 cycles → no overload.
5. dith_en=1, DITH_SHIFT=2 → dsm_dith matches a reference LFSR model from seed 0xACE1, shifted; dith_en=0 → dsm_dith=0. LFSR frozen in IDLE.
6. Overload and ovl_clr in the same cycle → ovl_flag stays 1. enable=0 mid-frame → IDLE next edge, dsm_reset=1. Reset asserted in RECOVER → all reset values next edge.

Source files
------------

// File: rtl/dsm_ctrl.sv
// -----------------------------------------------------------------------------
// dsm_ctrl : sequencer and supervisor for the delta-sigma modulator top.
//
// Sequences the modulator through IDLE -> FLUSH -> RUN, holds each accepted
// input sample on the modulator vin for OSR clocks, generates an LFSR dither
// word, and watches the 2-bit pwm code for overload. A run of OVL_LIMIT
// identical nonzero pwm codes forces a RECOVER (reset-and-resume) cycle.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   enable     in   run request (level)
//   dith_en    in   dither enable; 0 forces dsm_dith to 0
//   s_valid    in   input sample valid
//   s_data     in   input sample, T_BITS two's complement
//   s_ready    out  sample accepted this cycle (RUN and phase 0)
//   dsm_reset  out  modulator reset
//   dsm_vin    out  modulator input sample
//   dsm_dith   out  modulator dither word (T_BITS-5 bits)
//   pwm        in   modulator output code (00=0, 01=+, 11=-)
//   underrun   out  one-cycle pulse when a sample slot was missed
//   ovl_flag   out  sticky overload indicator
//   ovl_clr    in   clears ovl_flag (an overload in the same cycle wins)
//   ovl_count  out  overload event count, saturates at 255
//   state      out  00 IDLE, 01 FLUSH, 10 RUN, 11 RECOVER
// -----------------------------------------------------------------------------
module dsm_ctrl #(
    parameter int          T_BITS     = 15,
    parameter int          OSR        = 64,
    parameter int          RST_CYCLES = 4,
    parameter int          OVL_LIMIT  = 32,
    parameter int          DITH_SHIFT = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              dith_en,
    input  logic              s_valid,
    input  logic [T_BITS-1:0] s_data,
    output logic              s_ready,
    output logic              dsm_reset,
    output logic [T_BITS-1:0] dsm_vin,
    output logic [T_BITS-6:0] dsm_dith,
    input  logic [1:0]        pwm,
    output logic              underrun,
    output logic              ovl_flag,
    input  logic              ovl_clr,
    output logic [7:0]        ovl_count,
    output logic [1:0]        state
);

    localparam int DW = T_BITS - 5;
    localparam int PW = $clog2(OSR);
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int RW = $clog2(OVL_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FLUSH   = 2'b01,
        ST_RUN     = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [RW-1:0]       run_q, run_d, run_calc;
    logic [1:0]          pwm_prev_q, pwm_prev_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [T_BITS-1:0]   vin_q, vin_d;
    logic [DW-1:0]       dith_q, dith_d;
    logic                rst_q, rst_d;
    logic                underrun_q, underrun_d;
    logic                flag_q, flag_d;
    logic [7:0]          count_q, count_d;

    logic                ovl_hit;
    logic                ovl_evt;
    logic                ready_w;
    logic                xfer;
    logic signed [9:0]   dith_full;
    logic [DW-1:0]       dith_ext;

    // Length of the current run of identical nonzero pwm codes, including
    // this cycle's code.
    always_comb begin
        if (pwm != 2'b00 && pwm == pwm_prev_q) begin
            run_calc = run_q + RW'(1);
        end else if (pwm != 2'b00) begin
            run_calc = RW'(1);
        end else begin
            run_calc = '0;
        end
    end

    assign ovl_hit = (run_calc == RW'(OVL_LIMIT));

    // Next-state logic. Counters default to zero so every state entry
    // starts them cleanly (FLUSH/RECOVER count, RUN phase and run length).
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        phase_d = '0;
        run_d   = '0;
        ovl_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH, ST_RECOVER: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ovl_hit) begin
                    state_d = ST_RECOVER;
                    ovl_evt = 1'b1;
                end else begin
                    run_d   = run_calc;
                    phase_d = (phase_q == PW'(OSR - 1)) ? '0 : phase_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // s_ready depends on registered state only; no path from s_valid.
    assign ready_w = (state_q == ST_RUN) && (phase_q == '0);
    assign xfer    = ready_w && s_valid;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepping only while in RUN.
    assign lfsr_d = (state_q == ST_RUN)
                  ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]}
                  : lfsr_q;

    // Dither is built from the LFSR value that will be current when the
    // registered word is presented, so dsm_dith tracks lfsr in RUN.
    assign dith_full = $signed(lfsr_d[9:0]) >>> DITH_SHIFT;

    // Sign-extend (or truncate) the 10-bit shifted word to the port width.
    generate
        for (genvar gi = 0; gi < DW; gi++) begin : g_dith_ext
            assign dith_ext[gi] = dith_full[(gi < 10) ? gi : 9];
        end
    endgenerate

    always_comb begin
        vin_d      = vin_q;
        dith_d     = '0;
        rst_d      = (state_d != ST_RUN);
        underrun_d = ready_w && !s_valid;
        pwm_prev_d = (state_q == ST_RUN) ? pwm : pwm_prev_q;
        flag_d     = flag_q;
        count_d    = count_q;

        // Leaving RUN drops any in-flight sample.
        if (state_d != ST_RUN) begin
            vin_d = '0;
        end else if (xfer) begin
            vin_d = s_data;
        end

        if (state_d == ST_RUN && dith_en) begin
            dith_d = dith_ext;
        end

        if (ovl_evt) begin
            flag_d = 1'b1;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
        end else if (ovl_clr) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            phase_q    <= '0;
            run_q      <= '0;
            pwm_prev_q <= 2'b00;
            lfsr_q     <= LFSR_SEED;
            vin_q      <= '0;
            dith_q     <= '0;
            rst_q      <= 1'b1;
            underrun_q <= 1'b0;
            flag_q     <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            run_q      <= run_d;
            pwm_prev_q <= pwm_prev_d;
            lfsr_q     <= lfsr_d;
            vin_q      <= vin_d;
            dith_q     <= dith_d;
            rst_q      <= rst_d;
            underrun_q <= underrun_d;
            flag_q     <= flag_d;
            count_q    <= count_d;
        end
    end

    assign s_ready   = ready_w;
    assign dsm_reset = rst_q;
    assign dsm_vin   = vin_q;
    assign dsm_dith  = dith_q;
    assign underrun  = underrun_q;
    assign ovl_flag  = flag_q;
    assign ovl_count = count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_dsm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dsm_ctrl : directed self-checking bench for dsm_ctrl (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_dsm_ctrl;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        dith_en;
    logic        s_valid;
    logic [14:0] s_data;
    logic        s_ready;
    logic        dsm_reset;
    logic [14:0] dsm_vin;
    logic [9:0]  dsm_dith;
    logic [1:0]  pwm;
    logic        underrun;
    logic        ovl_flag;
    logic        ovl_clr;
    logic [7:0]  ovl_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    dsm_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .dith_en   (dith_en),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .dsm_reset (dsm_reset),
        .dsm_vin   (dsm_vin),
        .dsm_dith  (dsm_dith),
        .pwm       (pwm),
        .underrun  (underrun),
        .ovl_flag  (ovl_flag),
        .ovl_clr   (ovl_clr),
        .ovl_count (ovl_count),
        .state     (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %0h want 0", state); end
        checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL rst_dsm_reset got %0b want 1", dsm_reset); end
        checks++; if (dsm_vin !== 15'h0) begin errors++; $display("FAIL rst_vin got %h want 0", dsm_vin); end
        checks++; if (dsm_dith !== 10'h0) begin errors++; $display("FAIL rst_dith got %h want 0", dsm_dith); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %0b want 0", s_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %0b want 0", underrun); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL rst_ovl_flag got %0b want 0", ovl_flag); end
        checks++; if (ovl_count !== 8'd0) begin errors++; $display("FAIL rst_ovl_count got %0d want 0", ovl_count); end
        reset = 1'b0;
        tick;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_hold got %0h want 0", state); end
        $display("tb: reset values checked");
    endtask

    task automatic test_startup;
        int n;
        s_valid = 1'b1;
        s_data  = 15'h1234;
        enable  = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (state == 2'b10) break;
            if (state == 2'b01 && dsm_reset == 1'b1) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL flush_len got %0d want 4", n); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL start_run got %0h want 2", state); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL start_ready got %0b want 1", s_ready); end
        checks++; if (dsm_reset !== 1'b0) begin errors++; $display("FAIL start_dsm_reset got %0b want 0", dsm_reset); end
        $display("tb: startup flush cycles %0d", n);
    endtask

    task automatic test_handshake;
        int bad;
        int rdy;
        tick;
        checks++; if (dsm_vin !== 15'h1234) begin errors++; $display("FAIL hs_first got %h want 1234", dsm_vin); end
        s_data = 15'h7000;
        bad = 0;
        rdy = 0;
        for (int k = 2; k <= 64; k++) begin
            tick;
            if (dsm_vin !== 15'h1234) bad++;
            if (s_ready === 1'b1) rdy++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hs_hold bad_cycles %0d want 0", bad); end
        checks++; if (rdy !== 1) begin errors++; $display("FAIL hs_ready_count got %0d want 1", rdy); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_slot got %0b want 1", s_ready); end
        tick;
        checks++; if (dsm_vin !== 15'h7000) begin errors++; $display("FAIL hs_second got %h want 7000", dsm_vin); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_drop got %0b want 0", s_ready); end
        $display("tb: handshake 1234 then 7000 hold_bad %0d ready_count %0d", bad, rdy);
    endtask

    task automatic test_underrun;
        int pulses;
        int bad;
        s_valid = 1'b0;
        for (int k = 0; k < 63; k++) tick;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ur_slot got %0b want 1", s_ready); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_pre got %0b want 0", underrun); end
        tick;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse got %0b want 1", underrun); end
        checks++; if (dsm_vin !== 15'h7000) begin errors++; $display("FAIL ur_vin_hold got %h want 7000", dsm_vin); end
        s_valid = 1'b1;
        s_data  = 15'h0ABC;
        tick;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_single got %0b want 0", underrun); end
        pulses = 0;
        bad = 0;
        for (int k = 0; k < 62; k++) begin
            tick;
            if (underrun === 1'b1) pulses++;
            if (dsm_vin !== 15'h7000) bad++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL ur_extra_pulses got %0d want 0", pulses); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ur_hold bad_cycles %0d want 0", bad); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ur_next_slot got %0b want 1", s_ready); end
        tick;
        checks++; if (dsm_vin !== 15'h0ABC) begin errors++; $display("FAIL ur_next_hs got %h want 0abc", dsm_vin); end
        $display("tb: underrun pulse then handshake 0abc");
    endtask

    task automatic test_overload;
        int rc;
        int bad;
        pwm = 2'b01;
        for (int k = 0; k < 31; k++) tick;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL ovl_31_still_run got %0h want 2", state); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL ovl_31_flag got %0b want 0", ovl_flag); end
        tick;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL ovl_recover got %0h want 3", state); end
        checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL ovl_dsm_reset got %0b want 1", dsm_reset); end
        checks++; if (dsm_vin !== 15'h0) begin errors++; $display("FAIL ovl_vin got %h want 0", dsm_vin); end
        checks++; if (ovl_flag !== 1'b1) begin errors++; $display("FAIL ovl_flag got %0b want 1", ovl_flag); end
        checks++; if (ovl_count !== 8'd1) begin errors++; $display("FAIL ovl_count got %0d want 1", ovl_count); end
        pwm = 2'b00;
        rc = 1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (state == 2'b10) break;
            if (state == 2'b11 && dsm_reset == 1'b1) rc++;
        end
        checks++; if (rc !== 4) begin errors++; $display("FAIL recover_len got %0d want 4", rc); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL recover_exit got %0h want 2", state); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL recover_phase0 got %0b want 1", s_ready); end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            pwm = (i % 2 == 1) ? 2'b11 : 2'b01;
            tick;
            if (state !== 2'b10) bad++;
        end
        pwm = 2'b00;
        checks++; if (bad !== 0) begin errors++; $display("FAIL alt_pwm_not_run cycles %0d want 0", bad); end
        checks++; if (ovl_count !== 8'd1) begin errors++; $display("FAIL alt_pwm_count got %0d want 1", ovl_count); end
        checks++; if (ovl_flag !== 1'b1) begin errors++; $display("FAIL ovl_sticky got %0b want 1", ovl_flag); end
        ovl_clr = 1'b1;
        tick;
        ovl_clr = 1'b0;
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL ovl_clr got %0b want 0", ovl_flag); end
        $display("tb: overload recover_len %0d count %0d", rc, ovl_count);
    endtask

    task automatic test_dither;
        logic [15:0] m;
        logic [9:0]  exp_d;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        enable  = 1'b0;
        dith_en = 1'b1;
        s_valid = 1'b1;
        s_data  = 15'h0ABC;
        for (int k = 0; k < 5; k++) tick;
        checks++; if (dsm_dith !== 10'h0) begin errors++; $display("FAIL dith_idle got %h want 0", dsm_dith); end
        enable = 1'b1;
        for (int k = 0; k < 5; k++) tick;
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL dith_run got %0h want 2", state); end
        checks++; if (dsm_dith !== 10'h038) begin errors++; $display("FAIL dith_seed got %h want 038", dsm_dith); end
        m = 16'hACE1;
        for (int i = 0; i < 20; i++) begin
            exp_d = {{2{m[9]}}, m[9:2]};
            checks++; if (dsm_dith !== exp_d) begin errors++; $display("FAIL dith_seq[%0d] got %h want %h", i, dsm_dith, exp_d); end
            if (i == 1) begin
                checks++; if (dsm_dith !== 10'h39C) begin errors++; $display("FAIL dith_neg got %h want 39c", dsm_dith); end
            end
            m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
            tick;
        end
        checks++; if (dsm_vin !== 15'h0ABC) begin errors++; $display("FAIL dith_vin got %h want 0abc", dsm_vin); end
        dith_en = 1'b0;
        tick;
        m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        checks++; if (dsm_dith !== 10'h0) begin errors++; $display("FAIL dith_off got %h want 0", dsm_dith); end
        enable = 1'b0;
        tick;
        m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL disable_idle got %0h want 0", state); end
        checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL disable_dsm_reset got %0b want 1", dsm_reset); end
        checks++; if (dsm_vin !== 15'h0) begin errors++; $display("FAIL disable_vin got %h want 0", dsm_vin); end
        for (int k = 0; k < 10; k++) tick;
        dith_en = 1'b1;
        enable  = 1'b1;
        for (int k = 0; k < 5; k++) tick;
        exp_d = {{2{m[9]}}, m[9:2]};
        checks++; if (dsm_dith !== exp_d) begin errors++; $display("FAIL lfsr_frozen got %h want %h", dsm_dith, exp_d); end
        $display("tb: dither sequence and idle freeze checked");
    endtask

    task automatic test_ovl_clr_same_cycle;
        pwm = 2'b11;
        for (int k = 0; k < 31; k++) tick;
        ovl_clr = 1'b1;
        tick;
        ovl_clr = 1'b0;
        pwm = 2'b00;
        checks++; if (state !== 2'b11) begin errors++; $display("FAIL same_cyc_state got %0h want 3", state); end
        checks++; if (ovl_flag !== 1'b1) begin errors++; $display("FAIL same_cyc_flag got %0b want 1", ovl_flag); end
        checks++; if (ovl_count !== 8'd1) begin errors++; $display("FAIL same_cyc_count got %0d want 1", ovl_count); end
        $display("tb: overload with ovl_clr same cycle flag %0b", ovl_flag);
    endtask

    task automatic test_reset_in_recover;
        reset = 1'b1;
        tick;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rr_state got %0h want 0", state); end
        checks++; if (dsm_reset !== 1'b1) begin errors++; $display("FAIL rr_dsm_reset got %0b want 1", dsm_reset); end
        checks++; if (dsm_vin !== 15'h0) begin errors++; $display("FAIL rr_vin got %h want 0", dsm_vin); end
        checks++; if (dsm_dith !== 10'h0) begin errors++; $display("FAIL rr_dith got %h want 0", dsm_dith); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rr_s_ready got %0b want 0", s_ready); end
        checks++; if (ovl_flag !== 1'b0) begin errors++; $display("FAIL rr_flag got %0b want 0", ovl_flag); end
        checks++; if (ovl_count !== 8'd0) begin errors++; $display("FAIL rr_count got %0d want 0", ovl_count); end
        reset  = 1'b0;
        enable = 1'b0;
        tick;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rr_idle got %0h want 0", state); end
        $display("tb: reset during recover checked");
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        dith_en = 1'b0;
        s_valid = 1'b0;
        s_data  = 15'h0;
        pwm     = 2'b00;
        ovl_clr = 1'b0;
        test_reset;
        test_startup;
        test_handshake;
        test_underrun;
        test_overload;
        test_dither;
        test_ovl_clr_same_cycle;
        test_reset_in_recover;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
